// File: rtl/rv32_mem_pkg.sv
// Shared decode constants and enums for the RV32 data memory slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32_mem_pkg;

    // RV32I LOAD/STORE funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_e;

endpackage

// File: rtl/rv32_lsu_align.sv
// Byte/half lane extraction with sign/zero extension, and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; shared by the load response path and the RMW write path.
// Ports: word_i   - 32-bit word read from the array
//        wdata_i  - store data (low byte/half used for SB/SH)
//        off_i    - byte offset addr[1:0]
//        funct3_i - RV32I LOAD/STORE funct3
//        load_o   - extended load result
//        merge_o  - word_i with the store lane replaced
module rv32_lsu_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_o = {24'h0, byte_v};
            F3_H:    load_o = {{16{half_v[15]}}, half_v};
            F3_HU:   load_o = {16'h0, half_v};
            default: load_o = word_i;
        endcase

        merge_o = word_i;
        case (funct3_i)
            F3_B:    merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H:    merge_o = off_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                        : {word_i[31:16], wdata_i[15:0]};
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/rv32_dmem_ctrl.sv
// RV32 MEM-stage data memory: LB/LH/LW/LBU/LHU/SB/SH/SW with error flagging.
// Latency: load/SW response 1 cycle after accept, SB/SH 2 cycles; +1 with OUT_REG.
// Backpressure: req_ready drops for one cycle after an SB/SH accept (RMW bubble).
// Ports: clk/rst           - clock, synchronous active-high reset
//        req_valid/req_ready - request handshake; req_we/req_funct3/req_addr/req_wdata payload
//        rsp_valid         - one-cycle pulse per accepted request
//        rsp_rdata/rsp_err - extended load data (0 for stores/errors) and error code
module rv32_dmem_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int OUT_REG      = 0,
    parameter int INIT_SQUARES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);

    localparam int AW = $clog2(DEPTH);

    // Power-on image for the array; contents survive reset.
    function automatic logic [DEPTH-1:0][31:0] init_image();
        logic [DEPTH-1:0][31:0] img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = (INIT_SQUARES != 0) ? 32'(i * i) : 32'h0;
        end
        return img;
    endfunction

    logic [DEPTH-1:0][31:0] mem_q = init_image();

    state_e      state_q;
    logic        ready_q;
    logic        s1_vld_q;
    logic        s1_load_q;
    err_e        s1_err_q;
    logic [2:0]  s1_f3_q;
    logic [1:0]  s1_off_q;
    logic [AW-1:0] s1_idx_q;
    logic [31:0] s1_wdat_q;
    logic [31:0] rd_q;

    // Request decode
    logic        f3_legal;
    logic        is_half;
    logic        is_word;
    logic        misalign;
    logic        out_range;
    err_e        req_err;
    logic        accept;
    logic        rmw_start;
    logic        sw_write;
    logic [AW-1:0] req_idx;

    assign req_idx = req_addr[AW+1:2];

    always_comb begin
        is_half   = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
        is_word   = (req_funct3 == F3_W);
        if (req_we) begin
            f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
        end else begin
            f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W)
                    || (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
        end
        misalign  = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
        out_range = |req_addr[31:AW+2];

        if (!f3_legal) begin
            req_err = ERR_ILLEGAL;
        end else if (misalign) begin
            req_err = ERR_MISALIGN;
        end else if (out_range) begin
            req_err = ERR_RANGE;
        end else begin
            req_err = ERR_OK;
        end
    end

    assign accept    = req_valid && ready_q;
    // Legal stores are B/H/W only, so any non-W clean store is sub-word.
    assign rmw_start = accept && req_we && (req_err == ERR_OK) && (req_funct3 != F3_W);
    assign sw_write  = accept && req_we && (req_err == ERR_OK) && (req_funct3 == F3_W);
    assign req_ready = ready_q;

    logic [31:0] ld_dat;
    logic [31:0] merge_dat;

    // rd_q serves both as load data and as the old word for the RMW merge.
    rv32_lsu_align u_align (
        .word_i   (rd_q),
        .wdata_i  (s1_wdat_q),
        .off_i    (s1_off_q),
        .funct3_i (s1_f3_q),
        .load_o   (ld_dat),
        .merge_o  (merge_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_load_q <= 1'b0;
            s1_err_q  <= ERR_OK;
            s1_f3_q   <= 3'b000;
            s1_off_q  <= 2'b00;
            s1_idx_q  <= '0;
            s1_wdat_q <= 32'h0;
            rd_q      <= 32'h0;
        end else begin
            state_q  <= rmw_start ? RMW : IDLE;
            ready_q  <= !rmw_start;
            // The RMW response is released the cycle the merged word is written.
            s1_vld_q <= (accept && !rmw_start) || (state_q == RMW);
            if (accept) begin
                s1_load_q <= !req_we;
                s1_err_q  <= req_err;
                s1_f3_q   <= req_funct3;
                s1_off_q  <= req_addr[1:0];
                s1_idx_q  <= req_idx;
                s1_wdat_q <= req_wdata;
                rd_q      <= mem_q[req_idx];
            end
        end
    end

    // Word array; a reset in the RMW cycle drops the pending merge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sw_write) begin
                mem_q[req_idx] <= req_wdata;
            end else if (state_q == RMW) begin
                mem_q[s1_idx_q] <= merge_dat;
            end
        end
    end

    logic [31:0] s1_rdata;
    logic [1:0]  s1_err;

    assign s1_rdata = (s1_vld_q && s1_load_q && (s1_err_q == ERR_OK)) ? ld_dat : 32'h0;
    assign s1_err   = s1_vld_q ? s1_err_q : ERR_OK;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic        rsp_vld_q;
            logic [31:0] rsp_rdata_q;
            logic [1:0]  rsp_err_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_vld_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 2'b00;
                end else begin
                    rsp_vld_q   <= s1_vld_q;
                    rsp_rdata_q <= s1_rdata;
                    rsp_err_q   <= s1_err;
                end
            end

            assign rsp_valid = rsp_vld_q;
            assign rsp_rdata = rsp_rdata_q;
            assign rsp_err   = rsp_err_q;
        end else begin : g_no_out_reg
            assign rsp_valid = s1_vld_q;
            assign rsp_rdata = s1_rdata;
            assign rsp_err   = s1_err;
        end
    endgenerate

endmodule
